// File: rtl/core_mem_arb.sv
// core_mem_arb: shares the single memory read/write port between the core
// load/store unit (c_*) and the front-panel console (p_*). Each access is
// latched on grant, presented on m_* until m_rdy_i, acknowledged with a
// one-cycle *_rdy_o pulse, then followed by one bubble cycle.
//
// Ports:
//   clk_i, arst_ni            clock, asynchronous active-low reset
//   c_val_i/c_wen_i/c_addr_i/c_wdata_i -> c_rdy_o/c_rdata_o   core requester
//   p_val_i/p_wen_i/p_addr_i/p_wdata_i -> p_rdy_o/p_rdata_o   console requester
//   m_val_o/m_wen_o/m_addr_o/m_wdata_o <- m_rdy_i/m_rdata_i   memory port
//   busy_o                    an access is granted or in its bubble cycle
//
// Compile-time option:
//   MEM_ARB_RR_EN  defined   -> round-robin tie-break (loser of last grant wins)
//                  undefined -> fixed priority, core wins every tie
module core_mem_arb #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          c_val_i,
  input  logic          c_wen_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [DW-1:0] c_wdata_i,
  output logic          c_rdy_o,
  output logic [DW-1:0] c_rdata_o,
  input  logic          p_val_i,
  input  logic          p_wen_i,
  input  logic [AW-1:0] p_addr_i,
  input  logic [DW-1:0] p_wdata_i,
  output logic          p_rdy_o,
  output logic [DW-1:0] p_rdata_o,
  output logic          m_val_o,
  output logic          m_wen_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic          m_rdy_i,
  input  logic [DW-1:0] m_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner;     // 0 = core, 1 = console
  logic   grant;     // latch a new access this cycle
  logic   win;       // requester chosen when grant is high

`ifdef MEM_ARB_RR_EN
  logic last;

  // Tie goes to whoever did not win the previous grant.
  always_comb begin
    win = 1'b0;
    if (c_val_i && p_val_i) win = ~last;
    else                    win = p_val_i;
  end
`else
  // Fixed priority: console only wins when the core is not asking.
  always_comb begin
    win = ~c_val_i;
  end
`endif

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    m_val_o   = 1'b0;
    c_rdy_o   = 1'b0;
    p_rdy_o   = 1'b0;
    busy_o    = 1'b1;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (c_val_i || p_val_i) begin
          grant     = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        m_val_o = 1'b1;
        if (m_rdy_i) begin
          c_rdy_o   = ~owner;
          p_rdy_o   = owner;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and grant-time payload latch.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state     <= IDLE;
      owner     <= 1'b0;
      m_wen_o   <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner     <= win;
        m_wen_o   <= win ? p_wen_i   : c_wen_i;
        m_addr_o  <= win ? p_addr_i  : c_addr_i;
        m_wdata_o <= win ? p_wdata_i : c_wdata_i;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset to console so the core takes the first tie.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)   last <= 1'b1;
    else if (grant) last <= win;
  end
`endif

  // Read data is shared; each copy is meaningful only with its rdy.
  assign c_rdata_o = m_rdata_i;
  assign p_rdata_o = m_rdata_i;

endmodule

// File: tb/tb_core_mem_arb.sv
module tb_core_mem_arb;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          c_val_i, c_wen_i, p_val_i, p_wen_i;
  logic [AW-1:0] c_addr_i, p_addr_i;
  logic [DW-1:0] c_wdata_i, p_wdata_i;
  logic          c_rdy_o, p_rdy_o;
  logic [DW-1:0] c_rdata_o, p_rdata_o;
  logic          m_val_o, m_wen_o, m_rdy_i, busy_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o, m_rdata_i;

  core_mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .c_val_i(c_val_i), .c_wen_i(c_wen_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
    .c_rdy_o(c_rdy_o), .c_rdata_o(c_rdata_o),
    .p_val_i(p_val_i), .p_wen_i(p_wen_i), .p_addr_i(p_addr_i), .p_wdata_i(p_wdata_i),
    .p_rdy_o(p_rdy_o), .p_rdata_o(p_rdata_o),
    .m_val_o(m_val_o), .m_wen_o(m_wen_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_rdy_i(m_rdy_i), .m_rdata_i(m_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester-side stimulus state (index 0 = core, 1 = console).
  logic          rv[2];
  logic          rwen[2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rwd[2];
  bit            pend[2];   // holding a request, waiting for rdy
  bit            jdone[2];  // got rdy last cycle, must drop val now
  bit            drp[2];    // abandoned its request mid-access

  // Transaction-level reference: one access at a time, timestamps for gaps.
  bit            inflight;
  int            idle_at;
  bit            mown;
  bit            mlast;
  logic          mwen;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwd;
  int            wleft;
  int            force_wait = -1;
  logic [DW-1:0] mem[256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    inflight   = 1'b0;
    idle_at    = 0;
    mown       = 1'b0;
    mlast      = 1'b1;
    force_wait = -1;
    for (int r = 0; r < 2; r++) begin
      rv[r] = 1'b0; pend[r] = 1'b0; jdone[r] = 1'b0; drp[r] = 1'b0;
      rwen[r] = 1'b0; raddr[r] = '0; rwd[r] = '0;
    end
  endtask

  // mode: 0 random, 1 no new requests (m_rdy_i forced high outside grants),
  //       2 console-only new request, 3 both raise new requests
  task automatic step(input int mode);
    logic mrdy;
    logic ecrdy, eprdy;
    bit   w;
    @(negedge clk_i);
    for (int r = 0; r < 2; r++) begin
      if (jdone[r]) begin
        rv[r] = 1'b0; jdone[r] = 1'b0;
      end else if (drp[r]) begin
        rv[r] = 1'b0;
      end else if (pend[r]) begin
        if (mode == 0 && inflight && mown == r && $urandom_range(0, 7) == 0) begin
          rv[r] = 1'b0; drp[r] = 1'b1; pend[r] = 1'b0;
          raddr[r] = AW'($urandom);
        end
      end else begin
        if ((mode == 0 && $urandom_range(0, 1) == 1) || mode == 3 || (mode == 2 && r == 1)) begin
          rv[r] = 1'b1; pend[r] = 1'b1;
          rwen[r] = 1'($urandom_range(0, 1));
          raddr[r] = AW'($urandom_range(0, 15));
          rwd[r] = DW'($urandom);
        end
      end
    end
    c_val_i = rv[0]; c_wen_i = rwen[0]; c_addr_i = raddr[0]; c_wdata_i = rwd[0];
    p_val_i = rv[1]; p_wen_i = rwen[1]; p_addr_i = raddr[1]; p_wdata_i = rwd[1];

    if (inflight) begin
      mrdy = (wleft == 0);
      if (wleft > 0) wleft--;
    end else begin
      mrdy = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
    m_rdy_i   = mrdy;
    m_rdata_i = (inflight && mrdy && !mwen) ? mem[maddr] : DW'($urandom);
    #1;

    ecrdy = inflight && mrdy && !mown;
    eprdy = inflight && mrdy && mown;
    chk("m_val", 32'(m_val_o), 32'(inflight));
    chk("busy", 32'(busy_o), 32'(inflight || cyc < idle_at));
    chk("c_rdy", 32'(c_rdy_o), 32'(ecrdy));
    chk("p_rdy", 32'(p_rdy_o), 32'(eprdy));
    if (inflight) begin
      chk("m_addr", 32'(m_addr_o), 32'(maddr));
      chk("m_wen", 32'(m_wen_o), 32'(mwen));
      chk("m_wdata", 32'(m_wdata_o), 32'(mwd));
    end
    if (ecrdy && !mwen) chk("c_rdata", 32'(c_rdata_o), 32'(mem[maddr]));
    if (eprdy && !mwen) chk("p_rdata", 32'(p_rdata_o), 32'(mem[maddr]));

    if (inflight && mrdy) begin
      // completion: one bubble cycle follows, then idle again
      inflight = 1'b0;
      idle_at  = cyc + 2;
      if (mwen) mem[maddr] = mwd;
      jdone[mown] = 1'b1; drp[mown] = 1'b0; pend[mown] = 1'b0;
    end else if (!inflight && cyc >= idle_at && (rv[0] || rv[1])) begin
`ifdef MEM_ARB_RR_EN
      if (rv[0] && rv[1]) w = !mlast;
      else                w = rv[1];
`else
      w = !rv[0];
`endif
      mown = w; mlast = w;
      mwen = rwen[w]; maddr = raddr[w]; mwd = rwd[w];
      inflight = 1'b1;
      wleft = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    model_reset();
    arst_ni = 1'b0;
    c_val_i = 1'b0; c_wen_i = 1'b0; c_addr_i = '0; c_wdata_i = '0;
    p_val_i = 1'b0; p_wen_i = 1'b0; p_addr_i = '0; p_wdata_i = '0;
    m_rdy_i = 1'b1; m_rdata_i = '0;
    #12;
    chk("rst_m_val", 32'(m_val_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_c_rdy", 32'(c_rdy_o), 32'd0);
    chk("rst_p_rdy", 32'(p_rdy_o), 32'd0);
    chk("rst_m_addr", 32'(m_addr_o), 32'd0);
    chk("rst_m_wdata", 32'(m_wdata_o), 32'd0);
    chk("rst_m_wen", 32'(m_wen_o), 32'd0);
    @(negedge clk_i);
    m_rdy_i = 1'b0;
    arst_ni = 1'b1;

    // Both valid right out of reset: core must win the first tie.
    for (int i = 0; i < 12; i++) step(i == 0 ? 3 : 1);
    for (int i = 0; i < 400; i++) step(0);
    // Idle with m_rdy_i high: pending work drains, nothing else acknowledged.
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (!inflight && cyc > idle_at + 4 && !pend[0] && !pend[1]) break;
    end

    // Abort a wait-stated console access with an asynchronous reset.
    force_wait = 20;
    step(2);
    for (int i = 0; i < 3; i++) step(1);
    @(negedge clk_i);
    m_rdy_i = 1'b0;
    #2 arst_ni = 1'b0;
    #1 m_rdy_i = 1'b1;
    #1;
    chk("abort_m_val", 32'(m_val_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_p_rdy", 32'(p_rdy_o), 32'd0);
    chk("abort_m_addr", 32'(m_addr_o), 32'd0);
    model_reset();
    c_val_i = 1'b0; p_val_i = 1'b0;
    @(negedge clk_i);
    m_rdy_i = 1'b0;
    arst_ni = 1'b1;
    step(3);
    for (int i = 0; i < 200; i++) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/core_mem_arb.md
# core_mem_arb

Two-requester arbiter that shares the single read/write memory port between the core load/store unit and the front-panel console (examine/deposit). It sits between the core's `mem_rwport` master and the memory. It serialises accesses with a grant state machine and latches each request on grant. Fairness is round-robin or fixed-priority, selected at compile time.

## Interface
Parameters:
- `AW`, 8: address width (TOY 256-word memory).
- `DW`, 16: data width.

Ports:
- `clk_i` input 1: clock; all state on rising edge.
- `arst_ni` input 1: asynchronous reset, active-low.
- `c_val_i` input 1: core request valid.
- `c_wen_i` input 1: core write enable (1 = write).
- `c_addr_i` input AW: core address.
- `c_wdata_i` input DW: core write data.
- `c_rdy_o` output 1: core request completed this cycle.
- `c_rdata_o` output DW: core read data, valid when `c_rdy_o`.
- `p_val_i`, `p_wen_i`, `p_addr_i`, `p_wdata_i`, `p_rdy_o`, `p_rdata_o`: console requester; same widths and meanings as the core set.
- `m_val_o` output 1: memory request valid.
- `m_wen_o` output 1: memory write enable.
- `m_addr_o` output AW: memory address.
- `m_wdata_o` output DW: memory write data.
- `m_rdy_i` input 1: memory accepts/completes the request this cycle.
- `m_rdata_i` input DW: memory read data, valid with `m_rdy_i`.
- `busy_o` output 1: grant in flight.

## Operation
- States: IDLE, GRANT, DONE.
- IDLE: if any `*_val_i` is high, pick a winner and latch its `wen/addr/wdata` into the `m_*` registers. Record `owner` (0 = core, 1 = console) and go to GRANT. Otherwise stay.
- Arbitration when both are valid: grant the requester that is not `last`. Single valid: grant it. `last` updates to `owner` at each grant.
- GRANT: `m_val_o`=1 with the latched payload held stable. On `m_rdy_i`=1, assert `<owner>_rdy_o`=1 combinationally in the same cycle and go to DONE.
- DONE: one bubble cycle. All `rdy` and `m_val_o` are 0. The completing requester lowers or changes its `val` here. Next state is IDLE.
- `c_rdata_o` and `p_rdata_o` both pass `m_rdata_i` through. Each is meaningful only while its `rdy` is high.
- Requesters hold `val` and payload until `rdy`. The arbiter uses only the latched copy.
- If `val` drops during GRANT (protocol violation), the latched access still completes and the `rdy` pulse is still issued.
- A non-owner request is never acknowledged. It waits until it wins in IDLE.
- `busy_o` = (state != IDLE).
- Reset values: state IDLE, `last`=console (so the core wins the first tie), `owner`=0, all `m_*` outputs 0. `c_rdy_o`, `p_rdy_o` and `busy_o` are 0.

## Timing
- Request seen in IDLE at cycle N: `m_val_o` high from N+1.
- Zero-wait memory (`m_rdy_i` high at N+1): `rdy_o` pulses at N+1. DONE at N+2, IDLE at N+3.
- Minimum issue-to-issue spacing: 3 cycles. A request pending in IDLE at N+3 reaches `m_val_o` at N+4.
- Wait states: `rdy_o` pulses in the cycle `m_rdy_i` is first sampled high during GRANT. Each `rdy_o` is exactly one cycle wide.
- `m_rdy_i` high in IDLE or DONE is ignored.
- `arst_ni` low at any time, including mid-GRANT: immediate return to reset values. The in-flight access is abandoned with no `rdy`. The memory treats `m_val_o` deassertion as abort.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break using `last`, as described above.
- `MEM_ARB_RR_EN` undefined: fixed priority, core always wins ties. The `last` register is not implemented. The console is granted only in IDLE cycles with `c_val_i`=0.

## Test plan
- Core read, addr 0x42, memory returns 0x1234 with zero wait -> `m_val_o` at N+1 with `m_addr_o`=0x42 and `m_wen_o`=0; `c_rdy_o` at N+1 with `c_rdata_o`=0x1234; `p_rdy_o` never set.
- Console write, addr 0x10, data 0xBEEF, 2 memory wait states -> `m_wdata_o`=0xBEEF stable for 3 cycles; `p_rdy_o` single pulse at N+3; `busy_o` high N+1..N+4.
- Both requesters valid continuously from reset, RR enabled -> grant order core, console, core, console; completions 3 cycles apart. With the macro undefined -> core only; console starved.
- Core drops `c_val_i` mid-GRANT after a change of `c_addr_i` -> `m_addr_o` keeps the latched address; `c_rdy_o` still pulses once.
- `arst_ni` pulsed low during a wait-stated console access -> `m_val_o`, `busy_o` and `p_rdy_o` go 0 asynchronously. After release, tied requests grant the core first.
- `m_rdy_i` held high in IDLE with no requests -> no `rdy_o` pulse; state remains IDLE.
